// File: rtl/cam_pkg.sv
// Shared types, default geometry and the pixel format conversion for the camera capture path.
package cam_pkg;

    localparam int unsigned DEF_IMG_W  = 160;
    localparam int unsigned DEF_IMG_H  = 120;
    localparam int unsigned DEF_ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } cam_state_e;

    // RGB565 byte pair (high byte first on the wire) to RGB332.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with a third stage for rising/falling edge detection.
module cam_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise_c,
    output logic [W-1:0] fall_c
);

    logic [W-1:0] s1;
    logic [W-1:0] s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
            s3 <= q;
        end
    end

    assign rise_c = q & ~s3;
    assign fall_c = ~q & s3;

endmodule

// File: rtl/cam_capture.sv
// Oversampled camera byte capture: pairs RGB565 bytes, converts to RGB332 and writes
// one frame (or continuous frames) into a linear frame-buffer write port.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              pclk,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int unsigned COL_W  = $clog2(IMG_W + 1);
    localparam int unsigned LINE_W = $clog2(IMG_H + 1);

    cam_state_e state, state_d;

    logic pclk_unused_lvl, pclk_rise, pclk_unused_fall;
    logic href_s, href_unused_rise, href_fall;
    logic vsync_unused_lvl, vsync_rise, vsync_fall;

    logic [7:0]        data_s1, data_s2;
    logic              phase;
    logic [7:0]        hi_q, lo_q;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] line_base, pix_addr;
    logic              pix_pend;

    logic arm_c, cap_start_c, line_end_c, last_line_c, byte_c, err_set_c;

    cam_sync_edge #(.W(1)) u_sync_pclk (
        .clk(clk), .rst(rst), .d(pclk),
        .q(pclk_unused_lvl), .rise_c(pclk_rise), .fall_c(pclk_unused_fall)
    );

    cam_sync_edge #(.W(1)) u_sync_href (
        .clk(clk), .rst(rst), .d(href),
        .q(href_s), .rise_c(href_unused_rise), .fall_c(href_fall)
    );

    cam_sync_edge #(.W(1)) u_sync_vsync (
        .clk(clk), .rst(rst), .d(vsync),
        .q(vsync_unused_lvl), .rise_c(vsync_rise), .fall_c(vsync_fall)
    );

    // Next-state and control strobes.
    always_comb begin
        state_d     = state;
        arm_c       = 1'b0;
        cap_start_c = 1'b0;
        line_end_c  = (state == CAPTURE) && href_fall;
        last_line_c = (line == LINE_W'(IMG_H - 1));
        byte_c      = (state == CAPTURE) && pclk_rise && href_s;
        err_set_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    arm_c   = 1'b1;
                end
            end
            ARM: begin
                if (vsync_fall) begin
                    state_d     = CAPTURE;
                    cap_start_c = 1'b1;
                end
            end
            CAPTURE: begin
                if (line_end_c && phase)
                    err_set_c = 1'b1;
                if (byte_c && phase && (col >= COL_W'(IMG_W)))
                    err_set_c = 1'b1;
                if (line_end_c && last_line_c) begin
                    state_d = DONE;
                end else if (vsync_rise) begin
                    state_d   = DONE;
                    err_set_c = 1'b1;
                end
            end
            DONE: begin
                if (cont) begin
                    state_d = ARM;
                    arm_c   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            data_s1    <= '0;
            data_s2    <= '0;
            phase      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            col        <= '0;
            line       <= '0;
            line_base  <= '0;
            pix_addr   <= '0;
            pix_pend   <= 1'b0;
        end else begin
            state      <= state_d;
            busy       <= (state_d != IDLE);
            frame_done <= (state_d == DONE);
            err        <= arm_c ? 1'b0 : (err | err_set_c);
            data_s1    <= data;
            data_s2    <= data_s1;

            // Second stage of the pixel pipe: present the pixel latched last cycle.
            wr_en    <= pix_pend;
            pix_pend <= 1'b0;
            if (pix_pend) begin
                wr_addr <= pix_addr;
                wr_data <= rgb565_to_rgb332(hi_q, lo_q);
            end

            if (cap_start_c) begin
                line      <= '0;
                col       <= '0;
                phase     <= 1'b0;
                line_base <= '0;
            end else if (line_end_c) begin
                line      <= line + 1'b1;
                line_base <= line_base + ADDR_W'(IMG_W);
                col       <= '0;
                phase     <= 1'b0;
            end else if (byte_c) begin
                if (!phase) begin
                    hi_q  <= data_s2;
                    phase <= 1'b1;
                end else begin
                    lo_q  <= data_s2;
                    phase <= 1'b0;
                    // Pixels beyond the line width are dropped (flagged as error above).
                    if (col < COL_W'(IMG_W)) begin
                        pix_pend <= 1'b1;
                        pix_addr <= line_base + ADDR_W'(col);
                        col      <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a 4x2 image with clk running 8x pclk.
module tb_cam_capture;

    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 2;
    localparam int unsigned ADDR_W = 4;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst, start, cont, pclk, href, vsync;
    logic [7:0]        data;
    logic              wr_en, busy, frame_done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  rise_cyc = 0;
    bit  lat_req = 1'b0;
    bit  lat_pending = 1'b0;
    bit  m_cap = 1'b0;
    int  m_line = 0;
    int  m_col = 0;
    wr_t wr_q[$];
    bit  done_q[$];

    cam_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .pclk(pclk), .href(href), .vsync(vsync), .data(data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals frame end.
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_en", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
            check("wr_addr_in_range", 32'(wr_addr <= ADDR_W'(IMG_W * IMG_H - 1)), 32'd1);
            if (lat_pending) begin
                check("latency", 32'(cyc - rise_cyc), 32'd4);
                lat_pending = 1'b0;
            end
        end
        if (frame_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                bit e_err;
                e_err = done_q.pop_front();
                check("err_at_frame_done", 32'(err), 32'(e_err));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lat);
        data = b;
        wait_clk(4);
        pclk = 1'b1;
        if (lat) begin
            rise_cyc    = cyc;
            lat_pending = 1'b1;
        end
        wait_clk(4);
        pclk = 1'b0;
    endtask

    task automatic pixel(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ex);
        send_byte(hi, 1'b0);
        if (m_cap && m_col < int'(IMG_W))
            wr_q.push_back('{m_line * int'(IMG_W) + m_col, ex});
        m_col++;
        send_byte(lo, lat_req);
        lat_req = 1'b0;
    endtask

    task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] ex, input bit odd);
        href = 1'b1;
        wait_clk(2);
        for (int i = 0; i < npix; i++) pixel(hi, lo, ex);
        if (odd) send_byte(hi, 1'b0);
        wait_clk(2);
        href = 1'b0;
        m_line++;
        m_col = 0;
        wait_clk(8);
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        wait_clk(8);
        vsync  = 1'b0;
        m_line = 0;
        m_col  = 0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        wait_clk(8);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_clk(1);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0;
        pclk = 1'b0; href = 1'b0; vsync = 1'b1; data = 8'h00;
        wait_clk(3);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        wait_clk(4);

        // Clean frame F8/1F -> E3, with a start pulse while busy that must be ignored.
        pulse_start();
        wait_clk(1);
        check("busy_after_start", 32'(busy), 32'd1);
        done_q.push_back(1'b0);
        m_cap = 1'b1;
        frame_begin();
        send_line(4, 8'hF8, 8'h1F, 8'hE3, 1'b0);
        pulse_start();
        send_line(4, 8'hF8, 8'h1F, 8'hE3, 1'b0);
        m_cap = 1'b0;
        frame_end();
        check("busy_idle_a", 32'(busy), 32'd0);
        check("done_cnt_a", 32'(done_cnt), 32'd1);
        check("err_clean", 32'(err), 32'd0);

        // 07/E0 -> 1C with first-write latency check.
        pulse_start();
        done_q.push_back(1'b0);
        m_cap = 1'b1;
        frame_begin();
        lat_req = 1'b1;
        send_line(4, 8'h07, 8'hE0, 8'h1C, 1'b0);
        send_line(4, 8'h07, 8'hE0, 8'h1C, 1'b0);
        m_cap = 1'b0;
        frame_end();
        check("done_cnt_b", 32'(done_cnt), 32'd2);

        // Five pixels on a 4-wide line: extra pixel dropped, err raised.
        pulse_start();
        done_q.push_back(1'b1);
        m_cap = 1'b1;
        frame_begin();
        send_line(5, 8'hF8, 8'h1F, 8'hE3, 1'b0);
        send_line(4, 8'h07, 8'hE0, 8'h1C, 1'b0);
        m_cap = 1'b0;
        frame_end();
        check("err_sticky_idle", 32'(err), 32'd1);

        // Odd byte count: partial pixel dropped, next line realigned at addr 4.
        pulse_start();
        wait_clk(1);
        check("err_cleared_on_arm", 32'(err), 32'd0);
        done_q.push_back(1'b1);
        m_cap = 1'b1;
        frame_begin();
        send_line(3, 8'hA5, 8'h5A, 8'hB7, 1'b1);
        send_line(4, 8'h00, 8'hFF, 8'h03, 1'b0);
        m_cap = 1'b0;
        frame_end();
        check("done_cnt_d", 32'(done_cnt), 32'd4);

        // vsync rises after only one line: frame_done with err.
        pulse_start();
        done_q.push_back(1'b1);
        m_cap = 1'b1;
        frame_begin();
        send_line(4, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        m_cap = 1'b0;
        frame_end();
        check("done_cnt_e", 32'(done_cnt), 32'd5);
        check("busy_idle_e", 32'(busy), 32'd0);

        // Continuous mode over three frames.
        cont = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            logic [7:0] hi, lo, ex;
            hi = (f == 0) ? 8'hF8 : (f == 1) ? 8'h07 : 8'hA5;
            lo = (f == 0) ? 8'h1F : (f == 1) ? 8'hE0 : 8'h5A;
            ex = (f == 0) ? 8'hE3 : (f == 1) ? 8'h1C : 8'hB7;
            done_q.push_back(1'b0);
            m_cap = 1'b1;
            frame_begin();
            send_line(4, hi, lo, ex, 1'b0);
            if (f == 2) cont = 1'b0;
            send_line(4, hi, lo, ex, 1'b0);
            m_cap = 1'b0;
            frame_end();
            if (f < 2) check("busy_between_frames", 32'(busy), 32'd1);
        end
        check("done_cnt_cont", 32'(done_cnt), 32'd8);
        check("busy_after_cont", 32'(busy), 32'd0);

        // Reset mid-line right after addr 5 is written.
        pulse_start();
        m_cap = 1'b1;
        frame_begin();
        send_line(4, 8'hF8, 8'h1F, 8'hE3, 1'b0);
        href = 1'b1;
        wait_clk(2);
        pixel(8'h07, 8'hE0, 8'h1C);
        pixel(8'h07, 8'hE0, 8'h1C);
        wait_clk(2);
        m_cap = 1'b0;
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        rst = 1'b0;
        href = 1'b0;
        wait_clk(8);
        frame_begin();
        send_line(4, 8'hF8, 8'h1F, 8'hE3, 1'b0);
        send_line(4, 8'hF8, 8'h1F, 8'hE3, 1'b0);
        frame_end();
        check("done_cnt_after_rst", 32'(done_cnt), 32'd8);
        check("busy_after_rst", 32'(busy), 32'd0);

        wait_clk(4);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
